// File: rtl/sqz_block_seq.sv
// Sequencer for one SqueezeNext block: walks NUM_STAGES conv stages over a
// shared MAC datapath, producing read/weight/bias addressing and delayed writes.
// Ports: clk, rst (async active-low), start -> busy, done, in_load_ok, stage,
//   rd_bank, rd_addr, weight_addr, bias_sel, acc_clr, padding, skip_en,
//   skip_addr, wr_en, wr_bank, wr_addr (all registered).
module sqz_block_seq #(
    parameter int ADDR_WIDTH  = 10,
    parameter int NUM_STAGES  = 5,
    parameter int STAGE_W     = 3,
    parameter int IMG_W       = 8,
    parameter int IMG_H       = 8,
    parameter int G_WIDTH     = 4,
    parameter logic [NUM_STAGES*G_WIDTH-1:0] KIN =
        {4'd2, 4'd2, 4'd2, 4'd1, 4'd2},
    parameter logic [NUM_STAGES*G_WIDTH-1:0] KOUT =
        {4'd4, 4'd2, 4'd2, 4'd2, 4'd1},
    parameter logic [NUM_STAGES*2-1:0] PAD_MODE =
        {2'd0, 2'd2, 2'd1, 2'd0, 2'd0},
    parameter int WADDR_WIDTH = 8,
    parameter int LAT         = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   in_load_ok,
    output logic [STAGE_W-1:0]     stage,
    output logic [1:0]             rd_bank,
    output logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic [WADDR_WIDTH-1:0] weight_addr,
    output logic [G_WIDTH-1:0]     bias_sel,
    output logic                   acc_clr,
    output logic                   padding,
    output logic                   skip_en,
    output logic [ADDR_WIDTH-1:0]  skip_addr,
    output logic                   wr_en,
    output logic [1:0]             wr_bank,
    output logic [ADDR_WIDTH-1:0]  wr_addr
);

    localparam int PIX = IMG_W * IMG_H;
    localparam int I_W = (PIX > 1) ? $clog2(PIX) : 1;
    localparam logic [ADDR_WIDTH-1:0] PIX_A = ADDR_WIDTH'(PIX);
    localparam logic [G_WIDTH-1:0]    G_ONE = G_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state, nstate;
    logic [STAGE_W-1:0] s, ns;
    logic [G_WIDTH-1:0] p, np, k, nk;
    logic [I_W-1:0]     i, ni;
    logic [2:0]         dc, ndc;

    function automatic logic [G_WIDTH-1:0] kin_of(input logic [STAGE_W-1:0] st);
        return KIN[int'(st)*G_WIDTH +: G_WIDTH];
    endfunction

    function automatic logic [G_WIDTH-1:0] kout_of(input logic [STAGE_W-1:0] st);
        return KOUT[int'(st)*G_WIDTH +: G_WIDTH];
    endfunction

    function automatic logic [1:0] pad_of(input logic [STAGE_W-1:0] st);
        return PAD_MODE[int'(st)*2 +: 2];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            s     <= '0;
            p     <= '0;
            i     <= '0;
            k     <= '0;
            dc    <= '0;
        end else begin
            state <= nstate;
            s     <= ns;
            p     <= np;
            i     <= ni;
            k     <= nk;
            dc    <= ndc;
        end
    end

    // k innermost, then pixel, then output group
    always_comb begin
        nstate = state;
        ns     = s;
        np     = p;
        ni     = i;
        nk     = k;
        ndc    = dc;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    nstate = S_RUN;
                    ns     = '0;
                    np     = '0;
                    ni     = '0;
                    nk     = '0;
                end
            end
            S_RUN: begin
                if (k == kin_of(s) - G_ONE) begin
                    nk = '0;
                    if (i == I_W'(PIX - 1)) begin
                        ni = '0;
                        if (p == kout_of(s) - G_ONE) begin
                            np     = '0;
                            ndc    = '0;
                            nstate = S_DRAIN;
                        end else begin
                            np = p + G_ONE;
                        end
                    end else begin
                        ni = i + I_W'(1);
                    end
                end else begin
                    nk = k + G_ONE;
                end
            end
            S_DRAIN: begin
                if (dc == 3'(LAT - 1)) begin
                    if (s == STAGE_W'(NUM_STAGES - 1)) begin
                        nstate = S_DONE;
                    end else begin
                        nstate = S_RUN;
                        ns     = s + STAGE_W'(1);
                    end
                end else begin
                    ndc = dc + 3'd1;
                end
            end
            S_DONE: begin
                nstate = S_IDLE;
                ns     = '0;
            end
            default: nstate = S_IDLE;
        endcase
    end

    // Output values are derived from the next state so the registered
    // outputs line up with the counters they describe.
    logic                   n_run, n_busy, n_sched;
    logic [1:0]             n_rbank, n_wbank;
    logic [ADDR_WIDTH-1:0]  n_rd_a, n_pix_a;
    logic [WADDR_WIDTH-1:0] n_w_a;
    logic                   n_pad;
    int                     col, row;

    always_comb begin
        n_run   = (nstate == S_RUN);
        n_busy  = n_run || (nstate == S_DRAIN);
        n_sched = n_run && (nk == kin_of(ns) - G_ONE);
        n_rbank = (ns == '0) ? 2'd0 : (ns[0] ? 2'd1 : 2'd2);
        n_wbank = (ns == STAGE_W'(NUM_STAGES - 1)) ? 2'd3 :
                  (ns[0] ? 2'd2 : 2'd1);
        n_rd_a  = ADDR_WIDTH'(nk) * PIX_A + ADDR_WIDTH'(ni);
        n_pix_a = ADDR_WIDTH'(np) * PIX_A + ADDR_WIDTH'(ni);
        n_w_a   = WADDR_WIDTH'(np) * WADDR_WIDTH'(kin_of(ns))
                + WADDR_WIDTH'(nk);
        col     = int'(ni) % IMG_W;
        row     = int'(ni) / IMG_W;
        n_pad   = 1'b0;
        unique case (pad_of(ns))
            2'd1:    n_pad = (col == 0) || (col == IMG_W - 1);
            2'd2:    n_pad = (row == 0) || (row == IMG_H - 1);
            default: n_pad = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            in_load_ok  <= 1'b1;
            stage       <= '0;
            rd_bank     <= '0;
            rd_addr     <= '0;
            weight_addr <= '0;
            bias_sel    <= '0;
            acc_clr     <= 1'b0;
            padding     <= 1'b0;
            skip_en     <= 1'b0;
            skip_addr   <= '0;
        end else begin
            busy        <= n_busy;
            done        <= (nstate == S_DONE);
            in_load_ok  <= !n_busy;
            stage       <= n_busy ? ns : '0;
            rd_bank     <= n_run ? n_rbank : 2'd0;
            rd_addr     <= n_run ? n_rd_a : '0;
            weight_addr <= n_run ? n_w_a : '0;
            bias_sel    <= n_run ? np : '0;
            acc_clr     <= n_run && (nk == '0);
            padding     <= n_run && n_pad;
            skip_en     <= n_run && (ns == STAGE_W'(NUM_STAGES - 1));
            skip_addr   <= n_run ? n_pix_a : '0;
        end
    end

    // Slot 0 is aligned with the read; slot LAT drives the write port.
    logic                  pe [0:LAT];
    logic [ADDR_WIDTH-1:0] pa [0:LAT];
    logic [1:0]            pb [0:LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j <= LAT; j++) begin
                pe[j] <= 1'b0;
                pa[j] <= '0;
                pb[j] <= '0;
            end
        end else begin
            pe[0] <= n_sched;
            pa[0] <= n_sched ? n_pix_a : '0;
            pb[0] <= n_sched ? n_wbank : 2'd0;
            for (int j = 1; j <= LAT; j++) begin
                pe[j] <= pe[j-1];
                pa[j] <= pa[j-1];
                pb[j] <= pb[j-1];
            end
        end
    end

    assign wr_en   = pe[LAT];
    assign wr_addr = pa[LAT];
    assign wr_bank = pb[LAT];

endmodule

// File: doc/sqz_block_seq.md
# sqz_block_seq

Parametrised sequencer for one SqueezeNext block: runs NUM_STAGES convolution stages back-to-back over a shared 16-lane MAC/adder-tree datapath. For each stage it generates:
- activation read addresses, ping-pong bank selects, weight and bias-group selects;
- accumulator clear, border-padding flag and skip-add enable;
- delayed write strobes aligned to the datapath latency.

It sits between the upstream layer's input BRAM load and the downstream layer. Per-stage geometry (input/output channel groups, padding mode) is set by parameters rather than hard-coded per layer.

## Interface
Parameters:
- ADDR_WIDTH, 10, activation BRAM address width
- NUM_STAGES, 5, number of conv stages (1..8)
- STAGE_W, 3, width of stage index
- IMG_W, 8, feature-map width (pixels)
- IMG_H, 8, feature-map height; PIX = IMG_W*IMG_H
- G_WIDTH, 4, channel-group counter width
- KIN, {4'd2,4'd2,4'd2,4'd1,4'd2}, packed G_WIDTH per stage ({s4..s0}), input groups per stage, 1..15
- KOUT, {4'd4,4'd2,4'd2,4'd2,4'd1}, packed output groups per stage; KIN[s] must equal KOUT[s-1]
- PAD_MODE, {2'd0,2'd2,2'd1,2'd0,2'd0}, packed 2 bits per stage: 0 none, 1 column border, 2 row border
- WADDR_WIDTH, 8, weight ROM address width
- LAT, 3, datapath cycles from rd_addr to result (1..7)

Ports:
- clk in 1 — the single clock
- rst in 1 — reset, asynchronous, active-low
- start in 1 — one-cycle request to run the block; honoured only in IDLE
- busy out 1 — high from the cycle after accepted start until done
- done out 1 — one-cycle pulse after the last write of the last stage
- in_load_ok out 1 — equals ~busy; upstream may write bank IN
- stage out STAGE_W — current stage index
- rd_bank out 2 — 0 IN, 1 A, 2 B
- rd_addr out ADDR_WIDTH — k*PIX + i
- weight_addr out WADDR_WIDTH — p*KIN[s] + k
- bias_sel out G_WIDTH — current output group p
- acc_clr out 1 — high when k==0 (accumulator loads rather than adds)
- padding out 1 — zero-substitute flag for current pixel
- skip_en out 1 — high during all RUN cycles of the last stage
- skip_addr out ADDR_WIDTH — p*PIX + i
- wr_en out 1 — result write strobe
- wr_bank out 2 — 1 A, 2 B, 3 OUT
- wr_addr out ADDR_WIDTH — p*PIX + i, delayed

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE --start--> RUN, with s=0 and p=i=k=0.
  - RUN iterates: k innermost (0..KIN[s]-1), then pixel i (0..PIX-1), then p (0..KOUT[s]-1).
  - After the last triple, RUN -> DRAIN for exactly LAT cycles.
  - From DRAIN: if s<NUM_STAGES-1, go to RUN with s+1 and counters cleared; else go to DONE.
  - DONE -> IDLE after 1 cycle, with done=1 during that cycle.
- Banks by stage:
  - Stage 0 reads IN and writes A.
  - Odd stages read A and write B; even stages (s>0) read B and write A.
  - The last stage writes OUT regardless of parity.
- Padding (row = i/IMG_W, col = i%IMG_W):
  - Mode 1: flag when col==0 or col==IMG_W-1.
  - Mode 2: flag when row==0 or row==IMG_H-1.
  - Mode 0: flag never set.
- Writes: a write is scheduled in each RUN cycle where k==KIN[s]-1. A LAT-deep shift register carries wr_en, wr_addr and wr_bank.
- Address arithmetic is modulo 2^ADDR_WIDTH. A configuration where KOUT*PIX exceeds 2^ADDR_WIDTH is illegal; there is no runtime check.
- start while busy is ignored.

## Timing
- All outputs are registered. During reset and in IDLE, every output is 0 except in_load_ok=1.
- Read timing: the first rd_addr is valid in the cycle after start is sampled.
- Write timing: wr_en asserts LAT cycles after the rd_addr cycle with k==KIN[s]-1.
- Stage length: RUN lasts KOUT[s]*PIX*KIN[s] cycles, followed by LAT DRAIN cycles.
- Bubble: the next stage's first read follows the previous stage's last write with a 1-cycle bubble-free gap (read at T+LAT+1 after last read at T). This guarantees read-after-write on the ping-pong bank.
- busy and done: busy drops in the same cycle done pulses.
- Asynchronous reset mid-operation:
  - Forces IDLE in the same instant.
  - Flushes the write pipe, so no pending wr_en survives reset.
  - After release, a new start is required.
- KIN[s]==1: acc_clr and the write schedule are high every RUN cycle.

## Test plan
- Default params, single start -> stage 0 RUN is 128 cycles (rd_bank=0, wr_bank=1); 64 wr_en pulses at wr_addr 0..63; first wr_en 3 cycles after the first k==1 read.
- Full run, default params -> stages 0..4 in order:
  - wr_bank sequence A,B,A,B,OUT.
  - Total cycles are the sum of 128, 128, 256, 256, 512 plus 5×3 drain cycles.
  - done is a single pulse; busy falls with it.
- Stage 2 (PAD_MODE 1) -> padding high for i=0,7,8,15,...,63 (16 pixels per group pass); stage 3 (mode 2) -> high for i 0..7 and 56..63.
- Last stage -> skip_en high throughout RUN; skip_addr equals p*64+i; weight_addr reaches 4*2-1=7; bias_sel steps 0..3.
- start pulsed during stage 1 -> ignored, with no restart; a second start after done -> identical run.
- rst low during stage 2 DRAIN with a write pending -> no further wr_en; outputs zero; in_load_ok=1; after release, start runs from stage 0.
